// File: rtl/vv_alu_config_sequencer.sv
// Reconfiguration sequencer for a chain of vectorVectorALU-style blocks: stages
// firmware bytes from the host, then drains the pipeline and streams each block's bytes.
module vv_alu_config_sequencer #(
  parameter int         NUM_BLOCKS      = 2,
  parameter int         BYTES_PER_BLOCK = 20,
  parameter int         FIRST_CONFIG_ID = 1,
  parameter logic [7:0] NULL_ID         = 8'hFF,
  parameter int         DRAIN_CYCLES    = 4,
  parameter int         ADDR_W          = (NUM_BLOCKS * BYTES_PER_BLOCK > 1) ?
                                          $clog2(NUM_BLOCKS * BYTES_PER_BLOCK) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tracing_en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              start,
  input  logic              abort,
  output logic              tracing,
  output logic [7:0]        configId,
  output logic [7:0]        configData,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              wr_reject,
  output logic [2:0]        state_dbg
);

  localparam int DEPTH   = NUM_BLOCKS * BYTES_PER_BLOCK;
  localparam int BLK_W   = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam int BYTE_W  = (BYTES_PER_BLOCK > 1) ? $clog2(BYTES_PER_BLOCK) : 1;
  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [7:0]      FIRST_ID = 8'(FIRST_CONFIG_ID);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRAIN = 3'd1,
    S_SEND  = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4,
    S_ABORT = 3'd5
  } state_t;

  state_t             state;
  logic [BLK_W-1:0]   blk_cnt;
  logic [BYTE_W-1:0]  byte_cnt;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [ADDR_W-1:0]  rd_ptr;
  logic [7:0]         mem [DEPTH];
  logic               wr_ok;

  assign state_dbg = state;
  assign wr_ok     = wr_en && (state == S_IDLE) && ({1'b0, wr_addr} < DEPTH_L);

  always_ff @(posedge clk) begin
    if (!rst && wr_ok) mem[wr_addr] <= wr_data;
  end

  // Handshake toward the blocks: a byte is valid in exactly the cycle where
  // configId != NULL_ID; there is no ready, blocks must accept every such byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      blk_cnt    <= '0;
      byte_cnt   <= '0;
      drain_cnt  <= '0;
      rd_ptr     <= '0;
      tracing    <= 1'b0;
      configId   <= NULL_ID;
      configData <= 8'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      wr_reject  <= 1'b0;
    end else begin
      done      <= 1'b0;
      aborted   <= 1'b0;
      wr_reject <= wr_en && !wr_ok;
      case (state)
        S_IDLE: begin
          tracing    <= tracing_en;
          configId   <= NULL_ID;
          configData <= 8'd0;
          busy       <= 1'b0;
          if (start) begin
            state     <= S_DRAIN;
            drain_cnt <= DRAIN_W'(DRAIN_CYCLES - 1);
            blk_cnt   <= '0;
            byte_cnt  <= '0;
            rd_ptr    <= '0;
            tracing   <= 1'b0;
            busy      <= 1'b1;
          end
        end
        S_DONE, S_ABORT: begin
          state      <= S_IDLE;
          tracing    <= tracing_en;
          configId   <= NULL_ID;
          configData <= 8'd0;
          busy       <= 1'b0;
        end
        default: begin
          if (abort) begin
            state      <= S_ABORT;
            aborted    <= 1'b1;
            configId   <= NULL_ID;
            configData <= 8'd0;
          end else begin
            case (state)
              S_DRAIN: begin
                if (drain_cnt == '0) begin
                  state      <= S_SEND;
                  configId   <= FIRST_ID;
                  configData <= mem[rd_ptr];
                  rd_ptr     <= rd_ptr + ADDR_W'(1);
                end else begin
                  drain_cnt <= drain_cnt - DRAIN_W'(1);
                end
              end
              S_SEND: begin
                if (byte_cnt == BYTE_W'(BYTES_PER_BLOCK - 1)) begin
                  state      <= S_GAP;
                  configId   <= NULL_ID;
                  configData <= 8'd0;
                end else begin
                  byte_cnt   <= byte_cnt + BYTE_W'(1);
                  configData <= mem[rd_ptr];
                  rd_ptr     <= rd_ptr + ADDR_W'(1);
                end
              end
              S_GAP: begin
                // The NULL_ID cycle just driven resets each block's byte counter.
                if (blk_cnt != BLK_W'(NUM_BLOCKS - 1)) begin
                  state      <= S_SEND;
                  blk_cnt    <= blk_cnt + BLK_W'(1);
                  byte_cnt   <= '0;
                  configId   <= FIRST_ID + 8'(blk_cnt) + 8'd1;
                  configData <= mem[rd_ptr];
                  rd_ptr     <= rd_ptr + ADDR_W'(1);
                end else begin
                  state <= S_DONE;
                  done  <= 1'b1;
                end
              end
              default: state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vv_alu_config_sequencer.sv
// Table-driven bench for vv_alu_config_sequencer at default parameters, plus
// hand-written sequences on a minimal one-block, one-byte instance.
module tb_vv_alu_config_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       tracing_en;
  logic       wr_en, start, abort;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic       tracing, busy, done, aborted, wr_reject;
  logic [7:0] config_id, config_data;
  logic [2:0] state_dbg;

  logic       wr_en1, start1, abort1;
  logic [0:0] wr_addr1;
  logic [7:0] wr_data1;
  logic       tracing1, busy1, done1, aborted1, wr_reject1;
  logic [7:0] config_id1, config_data1;
  logic [2:0] state_dbg1;

  typedef struct {
    logic       rst, start, abort, wr_en;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic       e_tracing;
    logic [7:0] e_id, e_data;
    logic       e_busy, e_done, e_aborted, e_wr_reject;
  } vec_t;

  vec_t       vq[$];
  logic [7:0] exp_mem [40];
  logic [7:0] exp_q[$];
  int         n_applied = 0;
  int         n_err = 0;
  int         cyc = 0;

  logic       e1_busy [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [7:0] e1_id   [5] = '{8'hFF, 8'h01, 8'hFF, 8'hFF, 8'hFF};
  logic       e1_done [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic       e1_trc  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  vv_alu_config_sequencer u0 (
    .clk(clk), .rst(rst), .tracing_en(tracing_en), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .start(start), .abort(abort),
    .tracing(tracing), .configId(config_id), .configData(config_data),
    .busy(busy), .done(done), .aborted(aborted), .wr_reject(wr_reject),
    .state_dbg(state_dbg)
  );

  vv_alu_config_sequencer #(
    .NUM_BLOCKS(1), .BYTES_PER_BLOCK(1), .DRAIN_CYCLES(1)
  ) u1 (
    .clk(clk), .rst(rst), .tracing_en(tracing_en), .wr_en(wr_en1),
    .wr_addr(wr_addr1), .wr_data(wr_data1), .start(start1), .abort(abort1),
    .tracing(tracing1), .configId(config_id1), .configData(config_data1),
    .busy(busy1), .done(done1), .aborted(aborted1), .wr_reject(wr_reject1),
    .state_dbg(state_dbg1)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at step %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic vec_t idle_vec(input logic e_tracing);
    vec_t v;
    v = '{default: '0};
    v.e_tracing = e_tracing;
    v.e_id      = 8'hFF;
    return v;
  endfunction

  // One reconfiguration with start in step 0; optional abort/reset cut it short,
  // extra adds a start at 10 and a write to address 3 at 12 while busy.
  task automatic add_run(input int abort_at, input int rst_at, input bit extra);
    vec_t v;
    int   last;
    last = 48;
    if (abort_at >= 0) last = abort_at + 2;
    if (rst_at >= 0) last = rst_at + 2;
    for (int c = 0; c <= last; c++) begin
      v = idle_vec(1'b1);
      v.start   = (c == 0) || (extra && c == 10);
      v.wr_en   = extra && c == 12;
      v.wr_addr = 6'd3;
      v.wr_data = 8'h77;
      v.abort   = (c == abort_at);
      v.rst     = (c == rst_at);
      if (c != 0 && c != 48) begin
        v.e_busy    = 1'b1;
        v.e_tracing = 1'b0;
      end
      if (c >= 5 && c <= 24) begin
        v.e_id   = 8'd1;
        v.e_data = exp_mem[c-5];
      end
      if (c >= 26 && c <= 45) begin
        v.e_id   = 8'd2;
        v.e_data = exp_mem[c-6];
      end
      v.e_done      = (c == 47);
      v.e_wr_reject = extra && c == 13;
      if (abort_at >= 0 && c == abort_at + 1) begin
        v = idle_vec(1'b0);
        v.e_busy    = 1'b1;
        v.e_aborted = 1'b1;
      end
      if (abort_at >= 0 && c == abort_at + 2) v = idle_vec(1'b1);
      if (rst_at >= 0 && c == rst_at + 1) v = idle_vec(1'b0);
      if (rst_at >= 0 && c == rst_at + 2) v = idle_vec(1'b1);
      vq.push_back(v);
    end
  endtask

  task automatic drive(input vec_t v);
    rst     = v.rst;
    start   = v.start;
    abort   = v.abort;
    wr_en   = v.wr_en;
    wr_addr = v.wr_addr;
    wr_data = v.wr_data;
  endtask

  initial begin
    vec_t v;
    logic [7:0] e;
    int busy_n;

    rst = 1'b1; tracing_en = 1'b1;
    start = 1'b0; abort = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start1 = 1'b0; abort1 = 1'b0; wr_en1 = 1'b0; wr_addr1 = '0; wr_data1 = '0;
    for (int i = 0; i < 40; i++) exp_mem[i] = 8'(i);

    // vector table: reset, buffer fill, then the reconfiguration scenarios
    v = idle_vec(1'b0); v.rst = 1'b1; vq.push_back(v);
    v = idle_vec(1'b0); vq.push_back(v);
    for (int i = 0; i < 40; i++) begin
      v = idle_vec(1'b1);
      v.wr_en = 1'b1; v.wr_addr = 6'(i); v.wr_data = exp_mem[i];
      vq.push_back(v);
    end
    vq.push_back(idle_vec(1'b1));
    add_run(-1, -1, 1'b1);
    v = idle_vec(1'b1); v.wr_en = 1'b1; v.wr_addr = 6'd40; v.wr_data = 8'hEE; vq.push_back(v);
    v = idle_vec(1'b1); v.e_wr_reject = 1'b1; vq.push_back(v);
    vq.push_back(idle_vec(1'b1));
    add_run(15, -1, 1'b0);
    add_run(-1, 30, 1'b0);
    add_run(-1, -1, 1'b0);
    v = idle_vec(1'b1); vq.push_back(v);

    repeat (2) @(posedge clk);
    for (int k = 0; k < vq.size(); k++) begin
      @(posedge clk); #1;
      cyc = k;
      check("tracing",   tracing,     vq[k].e_tracing);
      check("configId",  config_id,   vq[k].e_id);
      check("configData",config_data, vq[k].e_data);
      check("busy",      busy,        vq[k].e_busy);
      check("done",      done,        vq[k].e_done);
      check("aborted",   aborted,     vq[k].e_aborted);
      check("wr_reject", wr_reject,   vq[k].e_wr_reject);
      if (k == 1) check("reset_state", state_dbg, 3'd0);
      drive(vq[k]);
    end

    // minimal instance: one block of one byte, one drain cycle
    cyc = 1000;
    @(posedge clk); #1;
    wr_en1 = 1'b1; wr_addr1 = 1'b0; wr_data1 = 8'hA5;
    @(posedge clk); #1;
    check("u1_wr_accept", wr_reject1, 1'b0);
    wr_addr1 = 1'b1; wr_data1 = 8'h5A;
    @(posedge clk); #1;
    check("u1_wr_reject", wr_reject1, 1'b1);
    wr_en1 = 1'b0; start1 = 1'b1;
    exp_q.push_back(8'hA5);
    busy_n = 0;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      start1 = 1'b0;
      cyc = 1000 + c;
      if (busy1) busy_n++;
      check("u1_busy",    busy1,      e1_busy[c-1]);
      check("u1_configId",config_id1, e1_id[c-1]);
      check("u1_done",    done1,      e1_done[c-1]);
      check("u1_tracing", tracing1,   e1_trc[c-1]);
      if (config_id1 != 8'hFF) begin
        if (exp_q.size() == 0) check("u1_extra_byte", config_id1, 8'hFF);
        else begin
          e = exp_q.pop_front();
          check("u1_data", config_data1, e);
        end
      end else begin
        check("u1_null_data", config_data1, 8'h00);
      end
    end
    check("u1_busy_cycles", busy_n, 4);
    check("u1_queue_empty", exp_q.size(), 0);

    // start and abort together in IDLE: start wins
    cyc = 1100;
    start1 = 1'b1; abort1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; abort1 = 1'b0;
    check("u1_start_wins_busy", busy1, 1'b1);
    check("u1_start_wins_noab", aborted1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("u1_start_wins_done", done1, 1'b1);
    @(posedge clk); #1;
    check("u1_final_idle", state_dbg1, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_err);
    $finish;
  end

endmodule
